// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and checksum helper for the UART command
// frame parser.
package uart_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;

  localparam int DEFAULT_TIMEOUT_CLKS = 8192;
  localparam int GAP_CNT_W            = 16;

  localparam logic [1:0] ERR_CHK     = 2'b01;
  localparam logic [1:0] ERR_CMD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_CMD  = 3'd1,
    GET_ADDR = 3'd2,
    GET_DATA = 3'd3,
    GET_CHK  = 3'd4
  } parser_state_t;

  // Plain 8-bit XOR over the payload bytes; no carry.
  function automatic logic [7:0] frame_chk(input logic [7:0] cmd,
                                           input logic [7:0] addr,
                                           input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// Clear/enable/expire gap counter. Expire fires on the cycle whose clock edge
// will bring the count to LIMIT-1; a clear on that same cycle suppresses it.
module uart_gap_timer #(
  parameter int WIDTH = 16,
  parameter int LIMIT = 8192
) (
  input  logic i_Clock,
  input  logic i_Rst_L,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expire
);

  localparam logic [WIDTH-1:0] LAST_CNT = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] PRE_CNT  = WIDTH'(LIMIT - 2);

  logic [WIDTH-1:0] count;

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      count <= '0;
    end else if (i_Clear) begin
      count <= '0;
    end else if (i_Enable && (count != LAST_CNT)) begin
      count <= count + 1'b1;
    end
  end

  assign o_Expire = i_Enable && !i_Clear && (count == PRE_CNT);

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte sync/cmd/addr/data/chk frames from the UART receiver and
// issues one-cycle register write/read requests or an error pulse with code.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
  input  logic       i_Clock,
  input  logic       i_Rst_L,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_En,
  output logic       o_Rd_En,
  output logic [7:0] o_Addr,
  output logic [7:0] o_Wr_Data,
  output logic       o_Frame_Err,
  output logic [1:0] o_Err_Code
);

  parser_state_t state, state_next;

  logic [7:0] cmd_q, addr_q, data_q;
  logic [7:0] cmd_d, addr_d, data_d;
  logic       wr_en_d, rd_en_d, err_d;
  logic [7:0] addr_out_d, wr_data_d;
  logic [1:0] err_code_d;
  logic       gap_expire;

  uart_gap_timer #(
    .WIDTH (GAP_CNT_W),
    .LIMIT (TIMEOUT_CLKS)
  ) u_gap_timer (
    .i_Clock  (i_Clock),
    .i_Rst_L  (i_Rst_L),
    .i_Clear  (i_Rx_DV),
    .i_Enable (state != IDLE),
    .o_Expire (gap_expire)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    err_d      = 1'b0;
    addr_out_d = o_Addr;
    wr_data_d  = o_Wr_Data;
    err_code_d = o_Err_Code;

    unique case (state)
      IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) state_next = GET_CMD;
      end
      GET_CMD: begin
        if (i_Rx_DV) begin
          cmd_d      = i_Rx_Byte;
          state_next = GET_ADDR;
        end
      end
      GET_ADDR: begin
        if (i_Rx_DV) begin
          addr_d     = i_Rx_Byte;
          state_next = GET_DATA;
        end
      end
      GET_DATA: begin
        if (i_Rx_DV) begin
          data_d     = i_Rx_Byte;
          state_next = GET_CHK;
        end
      end
      GET_CHK: begin
        // Checksum failure outranks an unknown command code.
        if (i_Rx_DV) begin
          state_next = IDLE;
          if (frame_chk(cmd_q, addr_q, data_q) != i_Rx_Byte) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end else if (cmd_q == CMD_WRITE) begin
            wr_en_d    = 1'b1;
            addr_out_d = addr_q;
            wr_data_d  = data_q;
          end else if (cmd_q == CMD_READ) begin
            rd_en_d    = 1'b1;
            addr_out_d = addr_q;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CMD;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (gap_expire) begin
      state_next = IDLE;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cmd_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      o_Wr_En     <= 1'b0;
      o_Rd_En     <= 1'b0;
      o_Frame_Err <= 1'b0;
      o_Addr      <= '0;
      o_Wr_Data   <= '0;
      o_Err_Code  <= '0;
    end else begin
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      o_Wr_En     <= wr_en_d;
      o_Rd_En     <= rd_en_d;
      o_Frame_Err <= err_d;
      o_Addr      <= addr_out_d;
      o_Wr_Data   <= wr_data_d;
      o_Err_Code  <= err_code_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: expected request/error pulses are queued
// as frames are driven and matched, with their cycle, when the DUT pulses.
module tb_uart_cmd_parser;

  localparam int LIMIT  = 8192;
  localparam int SPACED = 2560;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] rx_byte = 8'h00;

  logic       o_Wr_En, o_Rd_En, o_Frame_Err;
  logic [7:0] o_Addr, o_Wr_Data;
  logic [1:0] o_Err_Code;

  uart_cmd_parser #(.TIMEOUT_CLKS(LIMIT)) dut (
    .i_Clock     (clk),
    .i_Rst_L     (rst_n),
    .i_Rx_DV     (dv),
    .i_Rx_Byte   (rx_byte),
    .o_Wr_En     (o_Wr_En),
    .o_Rd_En     (o_Rd_En),
    .o_Addr      (o_Addr),
    .o_Wr_Data   (o_Wr_Data),
    .o_Frame_Err (o_Frame_Err),
    .o_Err_Code  (o_Err_Code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       wr;
    logic       rd;
    logic       err;
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] code;
    int         at_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int n_assert = 0;
  int n_fail   = 0;
  int drive_cyc = 0;

  logic [7:0] model_addr = 8'h00;
  logic [7:0] model_data = 8'h00;
  logic [1:0] model_code = 2'b00;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one byte strobe; gap==0 leaves DV high so the next byte follows back-to-back.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    @(negedge clk);
    dv        = 1'b1;
    rx_byte   = b;
    drive_cyc = cyc;
    if (gap > 0) begin
      @(negedge clk);
      dv = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic idleCycles(input int n);
    if (n > 0) begin
      @(negedge clk);
      dv = 1'b0;
      repeat (n - 1) @(negedge clk);
    end
  endtask

  function automatic logic [7:0] xorChk(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d);
    return c ^ a ^ d;
  endfunction

  task automatic expectFrame(input logic [7:0] c, input logic [7:0] a,
                             input logic [7:0] d, input logic [7:0] k);
    exp_t e;
    e.wr = 1'b0; e.rd = 1'b0; e.err = 1'b0;
    if (xorChk(c, a, d) !== k) begin
      e.err = 1'b1; model_code = 2'b01;
    end else if (c == 8'h57) begin
      e.wr = 1'b1; model_addr = a; model_data = d;
    end else if (c == 8'h52) begin
      e.rd = 1'b1; model_addr = a;
    end else begin
      e.err = 1'b1; model_code = 2'b10;
    end
    e.addr = model_addr; e.data = model_data; e.code = model_code;
    e.at_cyc = drive_cyc + 1;
    sb.push_back(e);
  endtask

  task automatic expectTimeout();
    exp_t e;
    model_code = 2'b11;
    e.wr = 1'b0; e.rd = 1'b0; e.err = 1'b1;
    e.addr = model_addr; e.data = model_data; e.code = model_code;
    e.at_cyc = drive_cyc + LIMIT;
    sb.push_back(e);
  endtask

  task automatic sendFrame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] k, input int gap, input int tail);
    applyStimulus(8'hA5, gap);
    applyStimulus(c, gap);
    applyStimulus(a, gap);
    applyStimulus(d, gap);
    applyStimulus(k, 0);
    expectFrame(c, a, d, k);
    idleCycles(tail);
  endtask

  task automatic waitDrain(input int budget, input string tag);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    checkOutput(tag, sb.size(), 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_wr_en"},    o_Wr_En,     0);
    checkOutput({tag, "_rd_en"},    o_Rd_En,     0);
    checkOutput({tag, "_frame_err"}, o_Frame_Err, 0);
    checkOutput({tag, "_addr"},     o_Addr,      0);
    checkOutput({tag, "_wr_data"},  o_Wr_Data,   0);
    checkOutput({tag, "_err_code"}, o_Err_Code,  0);
  endtask

  // Every pulse must match the oldest queued expectation, cycle included.
  always @(negedge clk) begin
    if (rst_n && (o_Wr_En || o_Rd_En || o_Frame_Err)) begin
      if (sb.size() == 0) begin
        checkOutput("spurious_pulse", {29'b0, o_Wr_En, o_Rd_En, o_Frame_Err}, 0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("pulse_cycle", cyc,         mon_e.at_cyc);
        checkOutput("wr_en",       o_Wr_En,     mon_e.wr);
        checkOutput("rd_en",       o_Rd_En,     mon_e.rd);
        checkOutput("frame_err",   o_Frame_Err, mon_e.err);
        checkOutput("addr",        o_Addr,      mon_e.addr);
        checkOutput("wr_data",     o_Wr_Data,   mon_e.data);
        checkOutput("err_code",    o_Err_Code,  mon_e.code);
      end
    end
  end

  initial begin
    #(1_500_000 * 10);
    $display("[TB] FAIL watchdog: observed no end of test, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  int d0;

  initial begin
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Non-sync bytes in IDLE must stay silent.
    applyStimulus(8'h00, 0);
    applyStimulus(8'hFF, 0);
    applyStimulus(8'h12, 1);
    idleCycles(20);
    waitDrain(5, "garbage_quiet");

    sendFrame(8'h57, 8'h10, 8'h3C, xorChk(8'h57, 8'h10, 8'h3C), SPACED, 3);
    waitDrain(10, "write_spaced");

    sendFrame(8'h57, 8'h10, 8'h3C, 8'h00, 2, 3);
    waitDrain(10, "bad_checksum");

    sendFrame(8'h52, 8'h22, 8'h00, 8'h70, 0, 3);
    waitDrain(10, "read_b2b");

    sendFrame(8'h41, 8'h01, 8'h02, 8'h42, 1, 3);
    waitDrain(10, "unknown_cmd");

    applyStimulus(8'hA5, 3);
    applyStimulus(8'h57, 0);
    expectTimeout();
    idleCycles(1);
    waitDrain(LIMIT + 20, "timeout_after_cmd");

    sendFrame(8'h57, 8'h05, 8'h06, 8'h54, 1, 3);
    waitDrain(10, "write_after_timeout");

    applyStimulus(8'hA5, 1);
    applyStimulus(8'h57, 1);
    applyStimulus(8'h01, 1);
    applyStimulus(8'h02, 0);
    expectTimeout();
    idleCycles(1);
    waitDrain(LIMIT + 20, "timeout_in_chk");

    // Next byte lands exactly on the would-be expiry cycle, then back-to-back
    // frames with the second sync arriving while the write pulse is high.
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h57, 0);
    d0 = drive_cyc;
    idleCycles(1);
    while (cyc < d0 + LIMIT - 2) @(negedge clk);
    applyStimulus(8'h10, 0);
    applyStimulus(8'h20, 0);
    applyStimulus(xorChk(8'h57, 8'h10, 8'h20), 0);
    expectFrame(8'h57, 8'h10, 8'h20, xorChk(8'h57, 8'h10, 8'h20));
    applyStimulus(8'hA5, 0);
    applyStimulus(8'h52, 0);
    applyStimulus(8'h33, 0);
    applyStimulus(8'h00, 0);
    applyStimulus(xorChk(8'h52, 8'h33, 8'h00), 0);
    expectFrame(8'h52, 8'h33, 8'h00, xorChk(8'h52, 8'h33, 8'h00));
    idleCycles(3);
    waitDrain(LIMIT + 20, "expiry_edge_b2b");

    sendFrame(8'h41, 8'h09, 8'h09, 8'h41, 1, 3);
    waitDrain(10, "err_code_nonzero");

    // Mid-frame reset: outputs clear asynchronously, partial frame is dropped.
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h57, 1);
    applyStimulus(8'h10, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("midframe_reset");
    model_addr = 8'h00;
    model_data = 8'h00;
    model_code = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LIMIT + 50) @(negedge clk);
    sendFrame(8'h57, 8'h44, 8'h55, xorChk(8'h57, 8'h44, 8'h55), 1, 3);
    waitDrain(10, "write_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
